// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor with a start/busy/done handshake.
//
// One full-adder/subtractor bit slice processes the operands LSB first, one
// bit per clock, keeping the carry (add) or borrow (subtract) in a flop.
// A WIDTH-bit operation takes WIDTH cycles after it is accepted.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous, active-high reset
//   start  - request. It is sampled in IDLE and DONE and ignored while busy.
//   a_ns   - mode, captured with start: 1 = a+b, 0 = a-b
//   a, b   - WIDTH-bit operands, captured with start
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse: result/cout/ovf have just been updated
//   result - sum or difference, modulo 2^WIDTH
//   cout   - add: carry out of the MSB. subtract: borrow (a < b unsigned).
//   ovf    - two's-complement signed overflow
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_add;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_ai;
    logic             w_bi;
    logic             w_ai_eff;
    logic             w_s;
    logic             w_c_next;
    logic             w_last;
    logic             w_ovf;

    // The operand registers shift right, so bit 0 always holds the current bit.
    // On the last bit, bit 0 holds the operand MSB.
    assign w_ai     = r_a[0];
    assign w_bi     = r_b[0];

    // The borrow out of a subtract is the carry MAJ(~a, b, borrow_in).
    assign w_ai_eff = r_add ? w_ai : ~w_ai;
    assign w_s      = w_ai ^ w_bi ^ r_c;
    assign w_c_next = (w_ai_eff & w_bi) | (w_ai_eff & r_c) | (w_bi & r_c);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // This value is used only on the last bit. At that point w_ai/w_bi are the
    // operand MSBs and w_s is the result MSB.
    assign w_ovf    = r_add ? ((w_ai == w_bi) && (w_s != w_ai))
                            : ((w_ai != w_bi) && (w_s != w_ai));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_add    <= 1'b0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_sum    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_add   <= a_ns;
                        r_cnt   <= '0;
                        r_c     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_c_next;
                    // The sum fills from the MSB side. After WIDTH shifts,
                    // bit 0 holds the first bit that was computed.
                    r_sum <= {w_s, r_sum[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= {w_s, r_sum[WIDTH-1:1]};
                        r_cout   <= w_c_next;
                        r_ovf    <= w_ovf;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
